// File: rtl/program_loader.sv
// program_loader: writes a byte-stream program image into the 16-bit
// instruction memory and holds the CPU in reset until the image has been
// written and its XOR checksum verified.
//
// Stream: LEN (N words), 2N data bytes high byte first, CSUM = XOR of all.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | after reset, waiting for Start
// LEN    | waiting for the length byte
// HI     | waiting for the high byte of the next word
// LO     | waiting for the low byte of the next word
// WRITE  | one-cycle memory write of the assembled word
// CSUM   | waiting for the checksum byte
// DONE   | image verified, CPU released from reset
// ERR    | bad length or checksum, CPU held in reset
module program_loader #(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [7:0]        byte_in_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic [ADDR_W-1:0] im_addr_o,
  output logic [15:0]       im_data_o,
  output logic              im_wr_o,
  output logic              cpu_reset_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [7:0]        word_count_o
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LEN   = 3'd1;
  localparam logic [2:0] ST_HI    = 3'd2;
  localparam logic [2:0] ST_LO    = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_CSUM  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;
  localparam logic [2:0] ST_ERR   = 3'd7;

  // 9 bits so the length compare cannot truncate DEPTH
  localparam logic [8:0] DEPTH_9 = 9'(DEPTH);

  logic [2:0]        state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic [7:0]        wc_q, wc_d;
  logic              ready_q, ready_d;
  logic              wr_q, wr_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept;

  assign accept = byte_valid_i & ready_q;

  // Next-state and datapath decode; flags are derived from the next state
  // so every output is a plain register aligned with the state it describes.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    csum_d  = csum_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wc_d    = wc_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) begin
          state_d = ST_LEN;
          wc_d    = 8'd0;
          addr_d  = '0;
          csum_d  = 8'd0;
        end
      end
      ST_LEN: begin
        if (accept) begin
          len_d  = byte_in_i;
          csum_d = byte_in_i;
          if ({1'b0, byte_in_i} > DEPTH_9) begin
            state_d = ST_ERR;
          end else if (byte_in_i == 8'd0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_HI;
          end
        end
      end
      ST_HI: begin
        if (accept) begin
          data_d[15:8] = byte_in_i;
          csum_d       = csum_q ^ byte_in_i;
          state_d      = ST_LO;
        end
      end
      ST_LO: begin
        if (accept) begin
          data_d[7:0] = byte_in_i;
          csum_d      = csum_q ^ byte_in_i;
          state_d     = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_d = addr_q + ADDR_W'(1);
        wc_d   = wc_q + 8'd1;
        if ((wc_q + 8'd1) == len_q) begin
          state_d = ST_CSUM;
        end else begin
          state_d = ST_HI;
        end
      end
      ST_CSUM: begin
        if (accept) begin
          state_d = (byte_in_i == csum_q) ? ST_DONE : ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output flags decoded from the upcoming state
  always_comb begin
    ready_d   = (state_d == ST_LEN) || (state_d == ST_HI) ||
                (state_d == ST_LO)  || (state_d == ST_CSUM);
    wr_d      = (state_d == ST_WRITE);
    busy_d    = ready_d || wr_d;
    cpu_rst_d = (state_d != ST_DONE);
    done_d    = (state_d == ST_DONE);
    err_d     = (state_d == ST_ERR);
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      len_q     <= 8'd0;
      csum_q    <= 8'd0;
      addr_q    <= '0;
      data_q    <= 16'd0;
      wc_q      <= 8'd0;
      ready_q   <= 1'b0;
      wr_q      <= 1'b0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      csum_q    <= csum_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wc_q      <= wc_d;
      ready_q   <= ready_d;
      wr_q      <= wr_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign byte_ready_o = ready_q;
  assign im_addr_o    = addr_q;
  assign im_data_o    = data_q;
  assign im_wr_o      = wr_q;
  assign cpu_reset_o  = cpu_rst_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = err_q;
  assign word_count_o = wc_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table vectors, hand-written corner sequences and
// random images checked against a stream-level reference model.
module tb_program_loader;

  typedef logic [7:0]  bq_t[$];
  typedef logic [22:0] wq_t[$];

  typedef struct {
    logic [7:0]  n;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [7:0]  cs;
    int          gap;
    logic        exp_done;
    logic        exp_err;
    logic [7:0]  exp_wc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_i, start_i, byte_valid_i;
  logic [7:0]  byte_in_i;
  logic        byte_ready_o, im_wr_o, cpu_reset_o, busy_o, done_o, error_o;
  logic [6:0]  im_addr_o;
  logic [15:0] im_data_o;
  logic [7:0]  word_count_o;

  int  checks = 0;
  int  errors = 0;
  int  cyc_cnt = 0;
  bit  mon_en = 0;
  wq_t wr_q;

  program_loader #(.ADDR_W(7), .DEPTH(128)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .byte_in_i    (byte_in_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .im_addr_o    (im_addr_o),
    .im_data_o    (im_data_o),
    .im_wr_o      (im_wr_o),
    .cpu_reset_o  (cpu_reset_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .word_count_o (word_count_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Capture memory writes and check cross-output invariants every cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (im_wr_o) wr_q.push_back({im_addr_o, im_data_o});
      checks++;
      if (cpu_reset_o !== ~done_o) begin
        errors++;
        $display("FAIL inv_cpu_reset: cpu_reset=%b done=%b at cycle %0d", cpu_reset_o, done_o, cyc_cnt);
      end
      checks++;
      if (busy_o !== (byte_ready_o | im_wr_o)) begin
        errors++;
        $display("FAIL inv_busy: busy=%b ready=%b wr=%b at cycle %0d", busy_o, byte_ready_o, im_wr_o, cyc_cnt);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: what a stream should produce, from the format rules alone
  function automatic void model(input bq_t s, output wq_t w, output bit ok,
                                output int wc, output int nbytes, output int lat);
    int n;
    logic [7:0] cs;
    w.delete();
    n = int'(s[0]);
    if (n > 128) begin
      ok = 0; wc = 0; nbytes = 1; lat = 2;
    end else begin
      cs = 8'd0;
      for (int i = 0; i < 2*n + 1; i++) cs = cs ^ s[i];
      for (int k = 0; k < n; k++) w.push_back({7'(k), s[1+2*k], s[2+2*k]});
      ok = (s[2*n+1] == cs);
      wc = n; nbytes = 2*n + 2; lat = 3*n + 3;
    end
  endfunction

  task automatic send_stream(input bq_t s, input int nbytes, input int gap);
    int idx = 0;
    int cyc = 0;
    logic v;
    while (idx < nbytes && cyc < 3000) begin
      @(negedge clk);
      start_i = 1'b0;
      if (cyc == 0) begin
        chk("busy_loading", 32'(busy_o), 32'd1);
        chk("cpu_reset_loading", 32'(cpu_reset_o), 32'd1);
        chk("done_cleared", 32'(done_o), 32'd0);
        chk("error_cleared", 32'(error_o), 32'd0);
      end
      case (gap)
        0:       v = 1'b1;
        1:       v = ((cyc % 2) == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      byte_valid_i = v;
      byte_in_i    = v ? s[idx] : 8'($urandom);
      if (v && byte_ready_o) idx++;
      cyc++;
    end
    if (idx < nbytes) begin
      checks++; errors++;
      $display("FAIL send_timeout: sent %0d bytes required %0d", idx, nbytes);
    end
  endtask

  task automatic wait_end();
    int k = 0;
    do begin
      @(negedge clk);
      byte_valid_i = 1'b0;
      start_i = 1'b0;
      k++;
    end while (!(done_o || error_o) && k < 10);
    if (!(done_o || error_o)) begin
      checks++; errors++;
      $display("FAIL end_timeout: done=%b error=%b required one set", done_o, error_o);
    end
  endtask

  task automatic check_result(input wq_t ew, input bit ok, input int ewc);
    chk("done", 32'(done_o), 32'(ok));
    chk("error", 32'(error_o), 32'(!ok));
    chk("cpu_reset", 32'(cpu_reset_o), 32'(!ok));
    chk("word_count", 32'(word_count_o), 32'(ewc));
    chk("busy_end", 32'(busy_o), 32'd0);
    chk("ready_end", 32'(byte_ready_o), 32'd0);
    chk("wr_count", 32'(wr_q.size()), 32'(ew.size()));
    for (int i = 0; i < wr_q.size() && i < ew.size(); i++)
      chk("wr_addr_data", 32'(wr_q[i]), 32'(ew[i]));
  endtask

  task automatic run_load(input bq_t s, input int gap);
    wq_t ew;
    bit  ok;
    int  ewc, nb, lat, t0;
    model(s, ew, ok, ewc, nb, lat);
    @(negedge clk);
    wr_q.delete();
    start_i = 1'b1;
    byte_valid_i = 1'b0;
    t0 = cyc_cnt;
    send_stream(s, nb, gap);
    wait_end();
    if (gap == 0) chk("latency", 32'(cyc_cnt - t0), 32'(lat));
    check_result(ew, ok, ewc);
  endtask

  task automatic check_reset_values();
    chk("rst_ready", 32'(byte_ready_o), 32'd0);
    chk("rst_wr", 32'(im_wr_o), 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_error", 32'(error_o), 32'd0);
    chk("rst_wc", 32'(word_count_o), 32'd0);
    chk("rst_addr", 32'(im_addr_o), 32'd0);
    chk("rst_data", 32'(im_data_o), 32'd0);
  endtask

  initial begin
    vec_t tbl[8];
    bq_t  s, s2;
    wq_t  ew;
    bit   ok;
    int   ewc, nb, lat, n;
    logic [15:0] w;
    logic [7:0]  cs;

    tbl[0] = '{8'h02, 16'h1234, 16'hABCD, 8'h42, 0, 1'b1, 1'b0, 8'd2};
    tbl[1] = '{8'h02, 16'h1234, 16'hABCD, 8'h43, 0, 1'b0, 1'b1, 8'd2};
    tbl[2] = '{8'h81, 16'h0000, 16'h0000, 8'h81, 0, 1'b0, 1'b1, 8'd0};
    tbl[3] = '{8'h00, 16'h0000, 16'h0000, 8'h00, 0, 1'b1, 1'b0, 8'd0};
    tbl[4] = '{8'h02, 16'h1234, 16'hABCD, 8'h42, 1, 1'b1, 1'b0, 8'd2};
    tbl[5] = '{8'h01, 16'hFFFF, 16'h0000, 8'h01, 0, 1'b1, 1'b0, 8'd1};
    tbl[6] = '{8'h01, 16'hFFFF, 16'h0000, 8'h00, 2, 1'b0, 1'b1, 8'd1};
    tbl[7] = '{8'h00, 16'h0000, 16'h0000, 8'h05, 1, 1'b0, 1'b1, 8'd0};

    rst_i = 1'b1; start_i = 1'b0; byte_valid_i = 1'b0; byte_in_i = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    rst_i = 1'b0;
    mon_en = 1;

    // table vectors
    for (int t = 0; t < 8; t++) begin
      s.delete();
      s.push_back(tbl[t].n);
      if (tbl[t].n <= 8'd2) begin
        for (int k = 0; k < int'(tbl[t].n); k++) begin
          w = (k == 0) ? tbl[t].w0 : tbl[t].w1;
          s.push_back(w[15:8]);
          s.push_back(w[7:0]);
        end
      end
      s.push_back(tbl[t].cs);
      run_load(s, tbl[t].gap);
      chk("tbl_done", 32'(done_o), 32'(tbl[t].exp_done));
      chk("tbl_error", 32'(error_o), 32'(tbl[t].exp_err));
      chk("tbl_wc", 32'(word_count_o), 32'(tbl[t].exp_wc));
    end

    // reset after the first word is written, then a full reload
    s = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    @(negedge clk);
    wr_q.delete();
    start_i = 1'b1;
    send_stream(s, 3, 0);
    @(negedge clk);
    byte_valid_i = 1'b0;
    chk("wr_before_reset", 32'(im_wr_o), 32'd1);
    chk("addr_before_reset", 32'(im_addr_o), 32'd0);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check_reset_values();
    run_load(s, 0);

    // Start pulse during a load is ignored
    model(s, ew, ok, ewc, nb, lat);
    @(negedge clk);
    wr_q.delete();
    start_i = 1'b1;
    send_stream(s, 3, 0);
    @(negedge clk);
    byte_valid_i = 1'b0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("midload_wc", 32'(word_count_o), 32'd1);
    chk("midload_busy", 32'(busy_o), 32'd1);
    chk("midload_addr", 32'(im_addr_o), 32'd1);
    s2 = '{8'hAB, 8'hCD, 8'h42};
    send_stream(s2, 3, 0);
    wait_end();
    check_result(ew, ok, ewc);

    // full-depth image
    s.delete();
    s.push_back(8'd128);
    cs = 8'd128;
    for (int i = 0; i < 256; i++) begin
      s.push_back(8'($urandom));
      cs = cs ^ s[i+1];
    end
    s.push_back(cs);
    run_load(s, 0);

    // random images
    for (int r = 0; r < 25; r++) begin
      s.delete();
      n = ($urandom_range(0, 9) == 9) ? int'($urandom_range(129, 255)) : int'($urandom_range(0, 5));
      s.push_back(8'(n));
      cs = 8'(n);
      if (n <= 128) begin
        for (int i = 0; i < 2*n; i++) begin
          s.push_back(8'($urandom));
          cs = cs ^ s[i+1];
        end
      end
      if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
      s.push_back(cs);
      run_load(s, int'($urandom_range(0, 2)));
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
